// File: rtl/spi_master_pkg.sv
// Shared types and constants for the SPI master arbiter: descriptor layout,
// transfer-mode encodings and FSM states.
package spi_master_pkg;

    localparam int unsigned DESC_W       = 112;
    localparam int unsigned OFS_ADDR     = 0;
    localparam int unsigned OFS_CMD      = 32;
    localparam int unsigned OFS_DUMMY    = 64;
    localparam int unsigned OFS_DATA_LEN = 80;
    localparam int unsigned OFS_ADDR_LEN = 96;
    localparam int unsigned OFS_CMD_LEN  = 102;
    localparam int unsigned OFS_CS       = 108;
    localparam int unsigned OFS_MODE     = 110;

    typedef enum logic [1:0] {
        MODE_RD  = 2'b00,
        MODE_WR  = 2'b01,
        MODE_QRD = 2'b10,
        MODE_QWR = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Field order matches the packed descriptor, MSB first
    typedef struct packed {
        mode_e       mode;
        logic [1:0]  cs;
        logic [5:0]  cmd_len;
        logic [5:0]  addr_len;
        logic [15:0] data_len;
        logic [15:0] dummy;
        logic [31:0] cmd;
        logic [31:0] addr;
    } desc_t;

    function automatic logic [3:0] cs_onehot(input logic [1:0] cs);
        return 4'b0001 << cs;
    endfunction

endpackage

// File: rtl/spi_rr_arb.sv
// Round-robin winner selection: first set request at or after ptr, wrapping.
module spi_rr_arb
    import spi_master_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] gnt
);

    logic w_found;

    always_comb begin
        gnt     = '0;
        w_found = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            for (int unsigned k = 0; k < N_REQ; k++) begin
                if (!w_found && req[k] && (k == ((32'(ptr) + i) % N_REQ))) begin
                    gnt[k]  = 1'b1;
                    w_found = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/spi_master_arbiter.sv
// Arbitrates N_REQ descriptor requesters onto one SPI controller, issues the
// start strobe, and guards each transfer with an optional watchdog.
module spi_master_arbiter
    import spi_master_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned TMO_W = 16
) (
    input  logic                    HCLK,
    input  logic                    HRESETn,
    input  logic [N_REQ-1:0]        req_i,
    input  logic [N_REQ*DESC_W-1:0] req_desc_i,
    input  logic [TMO_W-1:0]        tmo_i,
    input  logic                    eot_i,
    output logic [N_REQ-1:0]        gnt_o,
    output logic [N_REQ-1:0]        done_o,
    output logic [N_REQ-1:0]        err_o,
    output logic                    busy_o,
    output logic [31:0]             spi_cmd,
    output logic [31:0]             spi_addr,
    output logic [5:0]              spi_cmd_len,
    output logic [5:0]              spi_addr_len,
    output logic [15:0]             spi_data_len,
    output logic [15:0]             spi_dummy_rd,
    output logic [15:0]             spi_dummy_wr,
    output logic [3:0]              spi_csreg,
    output logic                    spi_rd,
    output logic                    spi_wr,
    output logic                    spi_qrd,
    output logic                    spi_qwr,
    output logic                    spi_swrst
);

    localparam int unsigned PTR_W = 2;

    state_e             r_state;
    logic [PTR_W-1:0]   r_rr_ptr;
    logic [PTR_W-1:0]   r_owner;
    logic [TMO_W-1:0]   r_wdog;

    logic [N_REQ-1:0]   w_gnt;
    logic [PTR_W-1:0]   w_win_idx;
    desc_t              w_desc;
    logic               w_tmo_hit;

    spi_rr_arb #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_arb (
        .req (req_i),
        .ptr (r_rr_ptr),
        .gnt (w_gnt)
    );

    // Mux the winner's descriptor and encode its index
    always_comb begin
        w_desc    = '0;
        w_win_idx = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (w_gnt[k]) begin
                w_desc    = desc_t'(req_desc_i[k*DESC_W +: DESC_W]);
                w_win_idx = PTR_W'(k);
            end
        end
    end

    assign w_tmo_hit = (tmo_i != '0) && (r_wdog == (tmo_i - TMO_W'(1)));

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state      <= ST_IDLE;
            r_rr_ptr     <= '0;
            r_owner      <= '0;
            r_wdog       <= '0;
            gnt_o        <= '0;
            done_o       <= '0;
            err_o        <= '0;
            busy_o       <= 1'b0;
            spi_cmd      <= '0;
            spi_addr     <= '0;
            spi_cmd_len  <= '0;
            spi_addr_len <= '0;
            spi_data_len <= '0;
            spi_dummy_rd <= '0;
            spi_dummy_wr <= '0;
            spi_csreg    <= '0;
            spi_rd       <= 1'b0;
            spi_wr       <= 1'b0;
            spi_qrd      <= 1'b0;
            spi_qwr      <= 1'b0;
            spi_swrst    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|req_i) begin
                        r_state      <= ST_ISSUE;
                        r_owner      <= w_win_idx;
                        gnt_o        <= w_gnt;
                        busy_o       <= 1'b1;
                        spi_cmd      <= w_desc.cmd;
                        spi_addr     <= w_desc.addr;
                        spi_cmd_len  <= w_desc.cmd_len;
                        spi_addr_len <= w_desc.addr_len;
                        spi_data_len <= w_desc.data_len;
                        spi_dummy_rd <= w_desc.dummy;
                        spi_dummy_wr <= w_desc.dummy;
                        spi_csreg    <= cs_onehot(w_desc.cs);
                        // Strobe registers rise with the grant so they are high exactly during ISSUE
                        spi_rd       <= (w_desc.mode == MODE_RD);
                        spi_wr       <= (w_desc.mode == MODE_WR);
                        spi_qrd      <= (w_desc.mode == MODE_QRD);
                        spi_qwr      <= (w_desc.mode == MODE_QWR);
                    end
                end
                ST_ISSUE: begin
                    spi_rd  <= 1'b0;
                    spi_wr  <= 1'b0;
                    spi_qrd <= 1'b0;
                    spi_qwr <= 1'b0;
                    r_wdog  <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (eot_i) begin
                        done_o  <= gnt_o;
                        r_state <= ST_DONE;
                    end else if (w_tmo_hit) begin
                        err_o     <= gnt_o;
                        spi_swrst <= 1'b1;
                        r_state   <= ST_DONE;
                    end else if (r_wdog != '1) begin
                        r_wdog <= r_wdog + TMO_W'(1);
                    end
                end
                ST_DONE: begin
                    done_o    <= '0;
                    err_o     <= '0;
                    spi_swrst <= 1'b0;
                    gnt_o     <= '0;
                    busy_o    <= 1'b0;
                    r_rr_ptr  <= (32'(r_owner) == (N_REQ - 1)) ? '0 : r_owner + PTR_W'(1);
                    r_state   <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/spi_master_arbiter.md
SPI_MASTER_ARBITER -- requirements
Module: spi_master_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters (2..4).
REQ-002 SHALL have parameter TMO_W, default 16, width of the watchdog counter.
REQ-003 SHALL have port HCLK  in  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port HRESETn  in  1  reset, asynchronous and active-low.
REQ-005 SHALL have port req_i  in  N_REQ  per-requester transaction request, level-held until grant.
REQ-006 SHALL have port req_desc_i  in  N_REQ*112  packed descriptors, requester k at bits [112k+111:112k].
REQ-007 SHALL have port tmo_i  in  TMO_W  watchdog limit in HCLK cycles; 0 disables the watchdog.
REQ-008 SHALL have port eot_i  in  1  end-of-transfer pulse from the SPI controller.
REQ-009 SHALL have port gnt_o  out  N_REQ  one-hot owner, held from ISSUE through DONE.
REQ-010 SHALL have port done_o  out  N_REQ  one-cycle completion pulse to the owner.
REQ-011 SHALL have port err_o  out  N_REQ  one-cycle timeout pulse to the owner.
REQ-012 SHALL have port busy_o  out  1  high whenever the state is not IDLE.
REQ-013 SHALL have ports spi_cmd/spi_addr (out, 32 each), spi_cmd_len/spi_addr_len (out, 6 each), and spi_data_len/spi_dummy_rd/spi_dummy_wr (out, 16 each), all driven from the latched descriptor.
REQ-014 SHALL have port spi_csreg  out  4  one-hot chip select decoded from the descriptor cs field.
REQ-015 SHALL have ports spi_rd, spi_wr, spi_qrd and spi_qwr, each out 1, as start strobes.
REQ-016 SHALL have port spi_swrst  out  1  controller/FIFO soft-reset on timeout.

Function
REQ-017 SHALL use descriptor layout, MSB first: mode[1:0], cs[1:0], cmd_len[5:0], addr_len[5:0], data_len[15:0], dummy[15:0], cmd[31:0], addr[31:0] (112 bits).
REQ-018 SHALL implement an FSM with states IDLE, ISSUE, WAIT, DONE.
REQ-019 IDLE: if any req_i is set, SHALL select a winner round-robin starting at rr_ptr, latch its descriptor, set gnt_o, and enter ISSUE on the next edge.
REQ-020 ISSUE: SHALL assert exactly one strobe for one cycle (mode 00 spi_rd, 01 spi_wr, 10 spi_qrd, 11 spi_qwr), clear the watchdog, and go to WAIT.
REQ-021 WAIT: on eot_i SHALL go to DONE with status OK.
REQ-021a WAIT: if tmo_i!=0 and the counter equals tmo_i-1, SHALL go to DONE with status TIMEOUT.
REQ-021b WAIT: if eot_i and the timeout coincide, eot_i SHALL win.
REQ-022 WAIT counter SHALL saturate at all-ones and SHALL not wrap.
REQ-023 DONE, single cycle: SHALL pulse done_o[owner] on OK.
REQ-023a DONE with status TIMEOUT: SHALL pulse err_o[owner] and spi_swrst together.
REQ-023b DONE: SHALL set rr_ptr to owner+1 modulo N_REQ, clear gnt_o at the next edge, and return to IDLE.
REQ-024 Latency: a request seen in IDLE at edge 0 SHALL produce the strobe during cycle 1; a request arriving while busy SHALL be served no earlier than two cycles after DONE.
REQ-025 SHALL keep spi_* descriptor outputs stable from ISSUE until the next grant.
REQ-025a SHALL ignore changes on req_desc_i or deassertion of req_i by the owner mid-transaction; the transaction completes normally.
REQ-026 SHALL ignore eot_i outside WAIT.
REQ-027 spi_dummy_rd and spi_dummy_wr SHALL both carry the descriptor dummy field; spi_csreg SHALL be 4'b0001 << cs.

Reset
REQ-028 HRESETn low SHALL asynchronously force state IDLE, rr_ptr 0, the watchdog counter 0, and every output to 0 (including spi_csreg 4'b0000), regardless of the current state.
REQ-029 Reset mid-transaction SHALL generate no done_o or err_o; spi_swrst SHALL stay 0 during and after reset.

Structure
REQ-030 The FSM state enum, DESC_W=112, the descriptor field offsets and the mode encodings SHALL live in shared package spi_master_pkg.
REQ-031 Round-robin winner selection SHALL be a sub-module spi_rr_arb (inputs req, ptr; output one-hot gnt); everything else stays flat.

Verification
REQ-032 Single request: req_i=0001, desc mode=01, cs=2, data_len=32 -> spi_wr high during cycle 1 only, spi_csreg=0100; eot_i at cycle 20 -> done_o=0001 at cycle 21, busy_o low at cycle 22.
REQ-033 Fairness: req_i=1111 held, eot_i 5 cycles after each strobe -> grant order 0,1,2,3,0 and no requester granted twice in a row.
REQ-034 Timeout: tmo_i=8 with no eot_i -> err_o[owner] and spi_swrst pulse together exactly once, 8 cycles after ISSUE; the next requester is granted afterwards.
REQ-035 Collision: eot_i on the same cycle the counter reaches tmo_i-1 -> done_o pulses, err_o and spi_swrst stay 0.
REQ-036 Reset in WAIT: HRESETn low for 1 cycle -> all outputs 0 immediately; a later eot_i produces no done_o; a fresh req_i=0010 is granted normally.
REQ-037 Descriptor change: alter req_desc_i of the owner during WAIT -> spi_cmd/spi_addr/spi_data_len unchanged until DONE.
